// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch engine: FSM states, decoded button events and the BCD time word.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        SPLIT,
        PAUSE,
        RECALL
    } state_e;

    typedef enum logic [2:0] {
        EV_NONE,
        EV_CLEAR,
        EV_STOP,
        EV_START,
        EV_SPLIT,
        EV_LAP,
        EV_RECALL
    } event_e;

    typedef struct packed {
        logic [3:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
        logic [3:0] s1;
        logic [3:0] s0;
        logic [3:0] c1;
        logic [3:0] c0;
    } bcd_time_t;

    localparam bcd_time_t BCD_MAX = 32'h9959_5999;

    // Highest value of digit idx, counted from c0 (idx 0) up to h1 (idx 7).
    function automatic logic [3:0] digit_max(input int idx);
        return (idx == 3 || idx == 5) ? 4'd5 : 4'd9;
    endfunction

endpackage

// File: rtl/bcd_time_counter.sv
// HH:MM:SS.CC BCD counter: single-cycle ripple carry across all digits, saturating at 99:59:59.99.
module bcd_time_counter
    import stopwatch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        tick_i,
    output logic [31:0] time_o,
    output logic        sat_o
);

    logic [31:0] time_reg;
    logic [31:0] time_next;
    logic [31:0] time_inc;
    logic [7:0]  carry;

    assign carry[0] = 1'b1;

    for (genvar gi = 0; gi < 8; gi++) begin : g_digit
        localparam logic [3:0] MAX = digit_max(gi);
        logic [3:0] digit;
        assign digit = time_reg[4*gi +: 4];
        assign time_inc[4*gi +: 4] = !carry[gi] ? digit :
                                     (digit == MAX) ? 4'd0 : digit + 4'd1;
        if (gi < 7) begin : g_carry
            assign carry[gi+1] = carry[gi] && (digit == MAX);
        end
    end

    assign sat_o = tick_i && (time_reg == BCD_MAX);

    always_comb begin
        time_next = time_reg;
        if (clr_i) begin
            time_next = '0;
        end else if (tick_i && !sat_o) begin
            time_next = time_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            time_reg <= '0;
        end else begin
            time_reg <= time_next;
        end
    end

    assign time_o = time_reg;

endmodule

// File: rtl/lap_stopwatch_core.sv
// Stopwatch engine: button FSM, centisecond prescaler, split latch, lap memory with recall, pause blink.
module lap_stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int TICK_HZ      = 100,
    parameter int BLINK_CYCLES = 25_000_000,
    parameter int LAP_DEPTH    = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start_i,
    input  logic                           stop_i,
    input  logic                           split_i,
    input  logic                           lap_i,
    input  logic                           recall_i,
    input  logic                           clear_i,
    output logic [31:0]                    time_o,
    output logic [31:0]                    disp_o,
    output logic                           disp_blank_o,
    output logic                           running_o,
    output logic [$clog2(LAP_DEPTH)-1:0]   lap_idx_o,
    output logic [$clog2(LAP_DEPTH):0]     lap_count_o,
    output logic                           lap_full_o,
    output logic                           overflow_o
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = $clog2(DIV);
    localparam int BW  = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
    localparam int IW  = $clog2(LAP_DEPTH);

    state_e          state_reg, state_next;
    event_e          ev;
    logic [PW-1:0]   presc_reg;
    logic [BW-1:0]   blink_cnt_reg;
    logic            blank_reg;
    logic            overflow_reg;
    logic [IW:0]     count_reg;
    logic [IW-1:0]   idx_reg;
    bcd_time_t       split_reg;
    bcd_time_t       lap_mem [LAP_DEPTH];
    logic [31:0]     time_cur;
    logic            running, tick, sat, full, clear_cmd, lap_we, idx_wrap;

    bcd_time_counter u_counter (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (clear_cmd),
        .tick_i (tick),
        .time_o (time_cur),
        .sat_o  (sat)
    );

    // Only the highest-priority pulse of a cycle is acted on.
    always_comb begin
        ev = EV_NONE;
        if (clear_i)       ev = EV_CLEAR;
        else if (stop_i)   ev = EV_STOP;
        else if (start_i)  ev = EV_START;
        else if (split_i)  ev = EV_SPLIT;
        else if (lap_i)    ev = EV_LAP;
        else if (recall_i) ev = EV_RECALL;
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:   if (ev == EV_START) state_next = RUN;
            RUN: begin
                if (ev == EV_STOP)       state_next = PAUSE;
                else if (ev == EV_SPLIT) state_next = SPLIT;
            end
            SPLIT: begin
                if (ev == EV_STOP)       state_next = PAUSE;
                else if (ev == EV_SPLIT) state_next = RUN;
            end
            PAUSE: begin
                if (ev == EV_CLEAR)                             state_next = IDLE;
                else if (ev == EV_START && !overflow_reg)       state_next = RUN;
                else if (ev == EV_RECALL && count_reg != '0)    state_next = RECALL;
            end
            RECALL: begin
                if (ev == EV_CLEAR)                         state_next = IDLE;
                else if (ev == EV_STOP || ev == EV_START)   state_next = PAUSE;
            end
            default: state_next = IDLE;
        endcase
        if (sat) state_next = PAUSE;
    end

    always_comb begin
        running = 1'b0;
        disp_o  = time_cur;
        case (state_reg)
            RUN:     running = 1'b1;
            SPLIT: begin
                running = 1'b1;
                disp_o  = split_reg;
            end
            RECALL:  disp_o = lap_mem[idx_reg];
            default: ;
        endcase
    end

    assign tick      = running && (presc_reg == PW'(DIV - 1));
    assign full      = (count_reg == (IW+1)'(LAP_DEPTH));
    assign clear_cmd = (ev == EV_CLEAR) && (state_reg == PAUSE || state_reg == RECALL);
    assign lap_we    = (ev == EV_LAP) && running && !full;
    assign idx_wrap  = ({1'b0, idx_reg} + (IW+1)'(1)) == count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_reg     <= '0;
            blink_cnt_reg <= '0;
            blank_reg     <= 1'b0;
            overflow_reg  <= 1'b0;
            count_reg     <= '0;
            idx_reg       <= '0;
            split_reg     <= '0;
        end else begin
            if (clear_cmd)    presc_reg <= '0;
            else if (tick)    presc_reg <= '0;
            else if (running) presc_reg <= presc_reg + PW'(1);

            if (clear_cmd) overflow_reg <= 1'b0;
            else if (sat)  overflow_reg <= 1'b1;

            if (clear_cmd)   count_reg <= '0;
            else if (lap_we) count_reg <= count_reg + (IW+1)'(1);

            if (clear_cmd || (state_reg == PAUSE && state_next == RECALL)) begin
                idx_reg <= '0;
            end else if (state_reg == RECALL && ev == EV_RECALL) begin
                idx_reg <= idx_wrap ? '0 : idx_reg + IW'(1);
            end

            if (state_reg == RUN && state_next == SPLIT) split_reg <= time_cur;

            // Blink phase restarts from "shown" every time PAUSE is (re)entered.
            if (state_reg == PAUSE && state_next == PAUSE) begin
                if (blink_cnt_reg == BW'(BLINK_CYCLES - 1)) begin
                    blink_cnt_reg <= '0;
                    blank_reg     <= ~blank_reg;
                end else begin
                    blink_cnt_reg <= blink_cnt_reg + BW'(1);
                end
            end else begin
                blink_cnt_reg <= '0;
                blank_reg     <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (lap_we) lap_mem[count_reg[IW-1:0]] <= time_cur;
    end

    assign time_o       = time_cur;
    assign disp_blank_o = blank_reg;
    assign running_o    = running;
    assign lap_idx_o    = idx_reg;
    assign lap_count_o  = count_reg;
    assign lap_full_o   = full;
    assign overflow_o   = overflow_reg;

endmodule

// File: tb/tb_lap_stopwatch_core.sv
// Directed bench for lap_stopwatch_core with 10 clk per centisecond, blink every 4 clk and 4 lap entries.
module tb_lap_stopwatch_core;

    localparam logic [5:0] P_CLEAR  = 6'b100000;
    localparam logic [5:0] P_STOP   = 6'b010000;
    localparam logic [5:0] P_START  = 6'b001000;
    localparam logic [5:0] P_SPLIT  = 6'b000100;
    localparam logic [5:0] P_LAP    = 6'b000010;
    localparam logic [5:0] P_RECALL = 6'b000001;

    logic        clk;
    logic        rst;
    logic        start_i, stop_i, split_i, lap_i, recall_i, clear_i;
    logic [31:0] time_o, disp_o;
    logic        disp_blank_o, running_o, lap_full_o, overflow_o;
    logic [1:0]  lap_idx_o;
    logic [2:0]  lap_count_o;

    int n_checks = 0;
    int n_fail   = 0;

    lap_stopwatch_core #(
        .CLK_HZ       (1000),
        .TICK_HZ      (100),
        .BLINK_CYCLES (4),
        .LAP_DEPTH    (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .split_i      (split_i),
        .lap_i        (lap_i),
        .recall_i     (recall_i),
        .clear_i      (clear_i),
        .time_o       (time_o),
        .disp_o       (disp_o),
        .disp_blank_o (disp_blank_o),
        .running_o    (running_o),
        .lap_idx_o    (lap_idx_o),
        .lap_count_o  (lap_count_o),
        .lap_full_o   (lap_full_o),
        .overflow_o   (overflow_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    // Drives a one-cycle pulse starting at a falling edge; returns on the next falling edge.
    task automatic pulse(input logic [5:0] m);
        {clear_i, stop_i, start_i, split_i, lap_i, recall_i} = m;
        @(negedge clk);
        {clear_i, stop_i, start_i, split_i, lap_i, recall_i} = 6'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, " time"},     time_o, 32'h0);
        check_val({tag, " disp"},     disp_o, 32'h0);
        check_val({tag, " blank"},    32'(disp_blank_o), 32'h0);
        check_val({tag, " running"},  32'(running_o), 32'h0);
        check_val({tag, " idx"},      32'(lap_idx_o), 32'h0);
        check_val({tag, " count"},    32'(lap_count_o), 32'h0);
        check_val({tag, " full"},     32'(lap_full_o), 32'h0);
        check_val({tag, " overflow"}, 32'(overflow_o), 32'h0);
    endtask

    logic [31:0] lap_exp [5];
    logic [1:0]  idx_exp [5];

    initial begin
        lap_exp = '{32'h0000_0060, 32'h0000_0080, 32'h0000_0100, 32'h0000_0120, 32'h0000_0060};
        idx_exp = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        rst = 1'b1;
        {clear_i, stop_i, start_i, split_i, lap_i, recall_i} = 6'b0;
        step(3);
        check_reset_outputs("reset");
        rst = 1'b0;

        // 1: run one second, pause, blink and hold
        pulse(P_START);
        check_val("t1 running", 32'(running_o), 32'h1);
        step(1000);
        check_val("t1 time 1s", time_o, 32'h0000_0100);
        pulse(P_STOP);
        check_val("t1 paused", 32'(running_o), 32'h0);
        check_val("t1 blank0", 32'(disp_blank_o), 32'h0);
        step(4);
        check_val("t1 blank1", 32'(disp_blank_o), 32'h1);
        step(4);
        check_val("t1 blank2", 32'(disp_blank_o), 32'h0);
        step(100);
        check_val("t1 time held", time_o, 32'h0000_0100);

        // 2: split freeze
        pulse(P_CLEAR);
        check_val("t2 cleared", time_o, 32'h0);
        pulse(P_START);
        step(500);
        check_val("t2 time 0.50", time_o, 32'h0000_0050);
        pulse(P_SPLIT);
        check_val("t2 split disp", disp_o, 32'h0000_0050);
        check_val("t2 split running", 32'(running_o), 32'h1);
        step(100);
        check_val("t2 time adv", time_o, 32'h0000_0060);
        check_val("t2 disp frozen", disp_o, 32'h0000_0050);
        pulse(P_SPLIT);
        check_val("t2 unsplit disp", disp_o, 32'h0000_0060);
        check_val("t2 unsplit time", time_o, 32'h0000_0060);

        // 3: fill lap memory, fifth lap ignored, recall with wrap
        for (int i = 0; i < 5; i++) begin
            if (i != 0) step(199);
            pulse(P_LAP);
        end
        check_val("t3 count", 32'(lap_count_o), 32'h4);
        check_val("t3 full", 32'(lap_full_o), 32'h1);
        pulse(P_STOP);
        for (int i = 0; i < 5; i++) begin
            pulse(P_RECALL);
            check_val($sformatf("t3 recall%0d disp", i), disp_o, lap_exp[i]);
            check_val($sformatf("t3 recall%0d idx", i), 32'(lap_idx_o), 32'(idx_exp[i]));
        end

        // 4: saturation
        pulse(P_CLEAR);
        check_val("t4 clear count", 32'(lap_count_o), 32'h0);
        check_val("t4 clear full", 32'(lap_full_o), 32'h0);
        check_val("t4 clear idx", 32'(lap_idx_o), 32'h0);
        force dut.u_counter.time_reg = 32'h9959_5998;
        step(1);
        release dut.u_counter.time_reg;
        check_val("t4 preload", time_o, 32'h9959_5998);
        pulse(P_START);
        step(30);
        check_val("t4 sat time", time_o, 32'h9959_5999);
        check_val("t4 overflow", 32'(overflow_o), 32'h1);
        check_val("t4 forced pause", 32'(running_o), 32'h0);
        pulse(P_START);
        check_val("t4 start ignored", 32'(running_o), 32'h0);
        check_val("t4 time kept", time_o, 32'h9959_5999);
        pulse(P_CLEAR);
        check_val("t4 clr time", time_o, 32'h0);
        check_val("t4 clr disp", disp_o, 32'h0);
        check_val("t4 clr overflow", 32'(overflow_o), 32'h0);
        step(4);
        check_val("t4 idle no blink", 32'(disp_blank_o), 32'h0);

        // 5: priority and lap coincident with tick
        pulse(P_START);
        step(19);
        pulse(P_LAP);
        check_val("t5 time after tick", time_o, 32'h0000_0002);
        check_val("t5 count", 32'(lap_count_o), 32'h1);
        pulse(P_STOP | P_START);
        check_val("t5 stop wins", 32'(running_o), 32'h0);
        pulse(P_RECALL);
        check_val("t5 pre-tick lap", disp_o, 32'h0000_0001);
        pulse(P_STOP);
        check_val("t5 back to pause", disp_o, 32'h0000_0002);
        pulse(P_CLEAR | P_RECALL);
        check_val("t5 clear wins count", 32'(lap_count_o), 32'h0);
        check_val("t5 clear wins disp", disp_o, 32'h0);

        // 6: reset mid-run, recall with no laps
        pulse(P_START);
        step(35);
        pulse(P_LAP);
        check_val("t6 lap stored", 32'(lap_count_o), 32'h1);
        rst = 1'b1;
        step(1);
        check_reset_outputs("t6 rst");
        rst = 1'b0;
        pulse(P_START);
        step(25);
        pulse(P_STOP);
        check_val("t6 paused time", time_o, 32'h0000_0002);
        pulse(P_RECALL);
        check_val("t6 recall ignored disp", disp_o, 32'h0000_0002);
        check_val("t6 recall ignored idx", 32'(lap_idx_o), 32'h0);
        step(3);
        check_val("t6 still pause blink", 32'(disp_blank_o), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
